// File: rtl/uart_text_loader.sv
// uart_text_loader: parses a framed program image from the UART byte stream
// (sync, word count, little-endian payload, XOR checksum) into text memory.
`default_nettype none

module uart_text_loader #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]   MAX_LEN = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_next;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [1:0]        lane;
  logic [7:0]        acc;
  logic [23:0]       partial;
  logic [TW-1:0]     timer;

  logic busy, start, do_write, set_done, set_err, hold_next;

  assign idx_inc = idx + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_next = state;
    start      = 1'b0;
    do_write   = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    busy       = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                 (state == S_DATA)   || (state == S_CHK);

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          state_next = S_LEN_LO;
          start      = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (rx_done) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_done) begin
          if ({1'b0, rx_data, len_lo} > MAX_LEN) begin
            state_next = S_ERR;
            set_err    = 1'b1;
          end else if ({rx_data, len_lo} == 16'd0) begin
            state_next = S_CHK;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_done && lane == 2'd3) begin
          do_write = 1'b1;
          if (16'(idx_inc) == len) state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (rx_data == acc) begin
            state_next = S_DONE;
            set_done   = 1'b1;
          end else begin
            state_next = S_ERR;
            set_err    = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // An arriving byte on the expiry cycle takes priority over the timeout.
    if (busy && !rx_done && timer == TO_LAST) begin
      state_next = S_ERR;
      set_err    = 1'b1;
    end
  end

  assign hold_next = (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                     (state_next == S_DATA)   || (state_next == S_CHK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len_lo    <= '0;
      len       <= '0;
      idx       <= '0;
      lane      <= '0;
      acc       <= '0;
      partial   <= '0;
      timer     <= '0;
    end else begin
      state    <= state_next;
      cpu_hold <= hold_next;
      we       <= do_write;

      if (busy && !rx_done) timer <= timer + TW'(1);
      else                  timer <= '0;

      if (start) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        idx       <= '0;
        lane      <= '0;
        acc       <= '0;
      end
      if (set_done) load_done <= 1'b1;
      if (set_err)  load_err  <= 1'b1;

      if (state == S_LEN_LO && rx_done) len_lo <= rx_data;
      if (state == S_LEN_HI && rx_done) len    <= {rx_data, len_lo};

      if (state == S_DATA && rx_done) begin
        acc  <= acc ^ rx_data;
        lane <= lane + 2'd1;
        case (lane)
          2'd0: partial[7:0]   <= rx_data;
          2'd1: partial[15:8]  <= rx_data;
          2'd2: partial[23:16] <= rx_data;
          default: begin
            waddr <= idx[ADDR_W-1:0];
            wdata <= {rx_data, partial};
            idx   <= idx_inc;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_text_loader.sv
// Self-checking bench for uart_text_loader: table-driven frames plus
// hand-written sequences for long frames, back-to-back, timeout and reset.
`default_nettype none

module tb_uart_text_loader;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold, load_done, load_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  wq_addr [$];
  logic [31:0] wq_data [$];
  int          wq_cyc  [$];

  uart_text_loader #(.WIDTH(32), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(waddr);
      wq_data.push_back(wdata);
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Called at a negedge; byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_good_frame(input int gap);
    logic [95:0] f;
    f = 96'hA50200_130000_009300_100090;
    for (int i = 0; i < 12; i++) send_byte(f[95-8*i -: 8], gap);
  endtask

  typedef struct {
    logic [95:0] bytes;
    int          n;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        hold_mid;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] chk;
    logic [7:0] b;

    vecs[0] = '{96'h00FF5A_000000_000000_000000,  3, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{96'hA50200_130000_009300_100090, 12, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{96'hA50200_130000_009300_100091, 12, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{96'hA50101_000000_000000_000000,  3, 0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
    vecs[4] = '{96'hA50000_000000_000000_000000,  4, 0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
    vecs[5] = '{96'hA50100_785634_120800_000000,  8, 1, 32'h12345678, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[6] = '{96'hA50000_010000_000000_000000,  4, 0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
    vecs[7] = '{96'h00FF5A_000000_000000_000000,  3, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", {24'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_flags", {30'd0, load_done, load_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      clear_q();
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(vecs[v].bytes[95-8*i -: 8], 1);
        if (i == 0) check($sformatf("v%0d_hold_mid", v), {31'd0, cpu_hold}, {31'd0, vecs[v].hold_mid});
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_nwrites", v), wq_data.size(), vecs[v].nw);
      if (vecs[v].nw >= 1 && wq_data.size() >= 1) begin
        check($sformatf("v%0d_addr0", v), {24'd0, wq_addr[0]}, 32'd0);
        check($sformatf("v%0d_data0", v), wq_data[0], vecs[v].w0);
      end
      if (vecs[v].nw >= 2 && wq_data.size() >= 2) begin
        check($sformatf("v%0d_addr1", v), {24'd0, wq_addr[1]}, 32'd1);
        check($sformatf("v%0d_data1", v), wq_data[1], vecs[v].w1);
      end
      check($sformatf("v%0d_done", v), {31'd0, load_done}, {31'd0, vecs[v].done});
      check($sformatf("v%0d_err", v), {31'd0, load_err}, {31'd0, vecs[v].err});
      check($sformatf("v%0d_hold_end", v), {31'd0, cpu_hold}, 32'd0);
    end

    // Back-to-back bytes: one write every 4 cycles
    clear_q();
    send_good_frame(0);
    repeat (2) @(negedge clk);
    check("b2b_nwrites", wq_data.size(), 2);
    if (wq_data.size() == 2) begin
      check("b2b_spacing", wq_cyc[1] - wq_cyc[0], 4);
      check("b2b_data0", wq_data[0], 32'h00000013);
      check("b2b_data1", wq_data[1], 32'h00100093);
    end
    check("b2b_done", {31'd0, load_done}, 32'd1);

    // Full-capacity frame: 256 words
    clear_q();
    chk = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int k = 0; k < 1024; k++) begin
      b = 8'(k);
      chk = chk ^ b;
      send_byte(b, 0);
    end
    send_byte(chk, 0);
    repeat (2) @(negedge clk);
    check("full_nwrites", wq_data.size(), 256);
    if (wq_data.size() == 256) begin
      check("full_first_data", wq_data[0], 32'h03020100);
      check("full_last_addr", {24'd0, wq_addr[255]}, 32'h000000FF);
      check("full_last_data", wq_data[255], 32'hFFFEFDFC);
    end
    check("full_done", {31'd0, load_done}, 32'd1);

    // Timeout: silence after a partial word
    clear_q();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_hold_before", {31'd0, cpu_hold}, 32'd1);
    check("to_err_before", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    check("to_hold_after", {31'd0, cpu_hold}, 32'd0);
    check("to_err_after", {31'd0, load_err}, 32'd1);
    check("to_nwrites", wq_data.size(), 0);

    // Byte arriving on the expiry cycle is accepted
    clear_q();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h00, 0);
    check("exp_hold", {31'd0, cpu_hold}, 32'd1);
    check("exp_err", {31'd0, load_err}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    repeat (2) @(negedge clk);
    check("exp_nwrites", wq_data.size(), 1);
    if (wq_data.size() == 1) check("exp_data", wq_data[0], 32'h00000013);
    check("exp_done", {31'd0, load_done}, 32'd1);

    // Asynchronous reset in the middle of DATA
    clear_q();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_waddr_wdata", wdata | {24'd0, waddr}, 32'd0);
    check("mid_rst_flags", {30'd0, load_done, load_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_q();
    send_good_frame(1);
    repeat (2) @(negedge clk);
    check("post_rst_nwrites", wq_data.size(), 2);
    if (wq_data.size() == 2) begin
      check("post_rst_data0", wq_data[0], 32'h00000013);
      check("post_rst_data1", wq_data[1], 32'h00100093);
    end
    check("post_rst_done", {31'd0, load_done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_text_loader.md
# uart_text_loader

Boot loader that sits between the UART receiver and instruction memory. It consumes the receiver's byte stream (`RX_DATA`/`RX_DONE`) and parses a framed program image: sync byte, word count, little-endian payload and XOR checksum. It writes each assembled 32-bit word into text memory through a single-cycle write port. It holds the processor in reset while a load is in progress, so the core restarts from PC 0 when the load ends.

## Interface
- `WIDTH`, 32: instruction word width; fixed at 32 (4 bytes per word).
- `ADDR_W`, 8: text-memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT`, 5_000_000: maximum idle cycles between bytes inside a frame before abort.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte; valid when `rx_done`=1.
- `rx_done`  in  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- `we`  out  1  text-memory write enable; one-cycle pulse per word.
- `waddr`  out  ADDR_W  word address for the write.
- `wdata`  out  WIDTH  word to write.
- `cpu_hold`  out  1  high while loading; OR'd into the processor RST.
- `load_done`  out  1  sticky; the last frame completed with a good checksum.
- `load_err`  out  1  sticky; the last frame was aborted (length, checksum or timeout).

## Operation
- **Frame format:** `0xA5`, then `LEN_LO`, `LEN_HI` (16-bit word count), then LEN×4 payload bytes (little-endian per word), then `CHK`.
  - `CHK` is the XOR of all payload bytes.
  - If LEN=0, `CHK` must be 0x00.
- **States:** IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- **IDLE, DONE, ERR:**
  - A byte of `0xA5` goes to LEN_LO.
  - That transition clears `load_done`, `load_err`, the word index, the byte lane and the checksum accumulator.
  - All other bytes are ignored.
- **LEN_LO → LEN_HI:** on the next byte.
- **LEN_HI:**
  - LEN > 2^ADDR_W: go to ERR.
  - LEN = 0: go to CHK.
  - Otherwise: go to DATA.
- **DATA:**
  - Each byte is placed in lane 0..3 (lane 0 = bits 7:0) and XORed into the accumulator.
  - On lane 3, the word is written at the current index and the index increments.
  - After the LEN-th word, go to CHK.
- **CHK:**
  - Byte equals the accumulator: go to DONE and set `load_done`.
  - Otherwise: go to ERR and set `load_err`. Words already written stay in memory.
- **`cpu_hold`:** high in LEN_LO, LEN_HI, DATA and CHK; low in IDLE, DONE and ERR.
- **Timeout:**
  - A cycle counter runs in LEN_LO through CHK and clears on every `rx_done`.
  - Reaching TIMEOUT goes to ERR.
  - If `rx_done` arrives on the expiry cycle, the byte wins: it is processed and the counter clears.
- **Width rules:**
  - The word index is ADDR_W+1 bits wide, so LEN=2^ADDR_W is legal and the final write lands at address 2^ADDR_W−1.
  - LEN is compared at full 16 bits.

## Timing
- **Reset values:** state IDLE; `we`, `cpu_hold`, `load_done`, `load_err` = 0; `waddr`, `wdata` = 0.
- **Output registering:** all outputs are registered. State, flags and `cpu_hold` update on the edge that samples the triggering `rx_done`.
- **Write pulse:** `we` is high for exactly the one cycle after the edge that samples the lane-3 `rx_done`. `waddr`/`wdata` are valid in that same cycle and hold until the next write.
- **Throughput:** one byte per cycle is sustained, so back-to-back `rx_done` gives one `we` every 4 cycles with no lost bytes.
- **`cpu_hold` edges:**
  - Rises the cycle after the sync byte is sampled.
  - Falls the cycle after the `CHK` byte or the timeout.
  - The last `we` precedes the fall by at least one cycle.
- **Reset mid-frame:** everything returns to reset values immediately (asynchronous). A partial word is never written.

## Test plan
- **Good load:** A5 02 00 13 00 00 00 93 00 10 00 90 → `we`@0 = 0x00000013, `we`@1 = 0x00100093, `load_done`=1, `load_err`=0, `cpu_hold` pulse spans the frame.
- **Bad checksum:** same frame with CHK=91 → both writes occur, `load_err`=1, `load_done`=0, `cpu_hold`=0 after the CHK byte.
- **Length limits:**
  - A5 01 01 → ERR right after LEN_HI; no `we`.
  - A5 00 01 (256 words) → last write at `waddr`=0xFF.
  - A5 00 00 00 → `load_done`=1 with no `we`.
- **Timeout:** A5 01 00 13 00, then silence for TIMEOUT cycles → `load_err`=1, `cpu_hold`=0, no `we`. A byte on the expiry cycle is accepted instead.
- **Noise and back-to-back:**
  - 00 FF 5A while in IDLE → no state change.
  - Good frame with `rx_done` high every cycle → `we` every 4th cycle with correct data.
- **Reset mid-DATA:** assert `rst` after 6 payload bytes → all outputs 0 at once. A following good frame loads correctly.
